// File: rtl/fns_enc_20_seq.sv
// Sequential greedy Fibonacci-numeral-system encoder: FBLEN20-bit binary in, 20-bit FNS codeword out, one bit per clock MSB first.
// Optional range check (err flag, zeroed codeword) enabled by defining FNS_ENC_RANGE_CHECK_EN.
`ifndef FBLEN20
`define FBLEN20 15
`endif
`ifndef FNS01
`define FNS01 1
`define FNS02 1
`define FNS03 2
`define FNS04 3
`define FNS05 5
`define FNS06 8
`define FNS07 13
`define FNS08 21
`define FNS09 34
`define FNS10 55
`define FNS11 89
`define FNS12 144
`define FNS13 233
`define FNS14 377
`define FNS15 610
`define FNS16 987
`define FNS17 1597
`define FNS18 2584
`define FNS19 4181
`define FNS20 6765
`endif

module fns_enc_20_seq (
    input  logic                clk,
    input  logic                rst,
    input  logic [`FBLEN20-1:0] datain,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [19:0]         codeout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                err
);
    localparam logic [`FBLEN20-1:0] W [20] = '{
        `FNS01, `FNS02, `FNS03, `FNS04, `FNS05, `FNS06, `FNS07, `FNS08, `FNS09, `FNS10,
        `FNS11, `FNS12, `FNS13, `FNS14, `FNS15, `FNS16, `FNS17, `FNS18, `FNS19, `FNS20};

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state, state_nx;
    logic [`FBLEN20-1:0] residual;
    logic [19:0]         code;
    logic [4:0]          k;
    logic                accept;
    logic                hit;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = CONV;
            end
            CONV: if (k == 5'd0) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = in_valid && (state == IDLE);
    assign hit    = residual >= W[k];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            residual <= '0;
            code     <= '0;
            k        <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                residual <= datain;
                code     <= '0;
                k        <= 5'd19;
            end else if (state == CONV) begin
                if (hit) begin
                    code[k]  <= 1'b1;
                    residual <= residual - W[k];
                end
                // Park k at 0 so the weight index never leaves 0..19.
                k <= (k == 5'd0) ? 5'd0 : k - 5'd1;
            end
        end
    end

`ifdef FNS_ENC_RANGE_CHECK_EN
    function automatic logic [`FBLEN20:0] w_sum();
        logic [`FBLEN20:0] s;
        s = '0;
        for (int i = 0; i < 20; i++) s = s + {1'b0, W[i]};
        return s;
    endfunction
    localparam logic [`FBLEN20:0] W_SUM = w_sum();

    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         err_q <= 1'b0;
        else if (accept) err_q <= ({1'b0, datain} > W_SUM);
    end

    assign err     = err_q;
    assign codeout = err_q ? 20'h00000 : code;
`else
    assign err     = 1'b0;
    assign codeout = code;
`endif
endmodule

// File: doc/fns_enc_20_seq.md
# fns_enc_20_seq

Sequential Fibonacci-numeral-system (FNS) encoder: converts a `FBLEN20`-bit binary word into a 20-bit FNS codeword, one codeword bit per clock, MSB first, using the greedy algorithm. It is the transmit-side counterpart of the FNS 20-bit decoder: for every in-range input, the decoder applied to this block's codeword must return the original value. It sits between the data source and the crosstalk-avoidance bus driver, with valid/ready handshakes on both sides.

## Interface
- Parameters: none. Weights come from `FNS01`..`FNS20` and the width from `FBLEN20`, all defined in FNS.vh.
- Weights: w[k] = `FNS(k+1)` = 1, 1, 2, 3, 5, …, 6765 for k = 0..19.
- Legal input range: 0..17710 (sum of all weights). `FBLEN20` = 15.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- datain  in  `FBLEN20`  binary value to encode.
- in_valid  in  1  datain is valid.
- in_ready  out  1  block can accept a word.
- codeout  out  20  FNS codeword; bit k carries weight w[k].
- out_valid  out  1  codeout and err are valid.
- out_ready  in  1  consumer accepts codeout.
- err  out  1  input was out of range. Present only with the range-check macro; otherwise tied to 0.

## Operation
- FSM states:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch datain into the residual register, clear the code register, set k = 19, and go to CONV.
  - CONV: on each cycle, if residual >= w[k], then code[k] = 1 and residual -= w[k]; otherwise code[k] = 0. Then decrement k. After the k = 0 step, go to DONE.
  - DONE: out_valid = 1. codeout and err are held stable. On out_ready, go to IDLE.
- The residual is `FBLEN20` bits wide, and each comparison is unsigned. The greedy order makes the residual exactly 0 after k = 0 for every in-range input.
- in_ready is 0 in CONV and DONE. A word offered with in_valid outside IDLE is not consumed.
- datain and in_valid are sampled only on the acceptance edge. Later changes to them have no effect on the conversion in progress.
- out_valid rises only in DONE and stays high until the out_ready handshake completes (no drop while stalled).
- Reset, including mid-conversion: state returns to IDLE, residual, code and k clear, and any partial result is discarded.
- Reset values: in_ready = 1, out_valid = 0, codeout = 20'h00000, err = 0.

## Timing
- Latency: the acceptance edge is E0. Bit 19 is resolved on E1 and bit 0 on E20. out_valid is high from the cycle after E20.
- Latency is fixed at 20 cycles for every input, including 0 and out-of-range values.
- DONE→IDLE: the out_ready handshake on edge Ed brings in_ready high from the cycle after Ed, so the next acceptance is at Ed+1 at the earliest.
- Peak throughput is one word per 22 cycles when out_ready is held high.
- No combinational path exists from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- FNS_ENC_RANGE_CHECK_EN:
  - Defined: at acceptance, datain > 17710 sets a sticky err flag for that word. When err = 1, codeout is forced to 20'h00000 in DONE. The FSM timing is unchanged. err clears on the next acceptance.
  - Not defined: err is constant 0 and no comparator is built. Out-of-range inputs encode greedily and saturate to 20'hFFFFF.

## Test plan
- Reset mid-CONV: assert rst around cycle 10 of a conversion of 100 → immediately in_ready = 1, out_valid = 0, codeout = 0. The next word encodes correctly.
- Directed values, out_ready held high, each with out_valid exactly 20 cycles after acceptance:
  - 0 → 20'h00000
  - 1 → 20'h00002
  - 100 → 20'h00428
  - 6765 → 20'h80000
  - 17710 → 20'hFFFFF
- Backpressure: hold out_ready = 0 for 7 cycles after out_valid rises → codeout is stable and in_ready stays 0. A second in_valid is not accepted until 1 cycle after the handshake.
- Round trip: 2000 random in-range values through the encoder and the 20-bit FNS decoder → decoded value equals input every time, and the final residual is 0.
- Range check, macro defined: 17711 → err = 1 and codeout = 20'h00000. The following value 5 → err = 0 and codeout = 20'h00010.
- Range check, macro not defined: 17711 → err = 0 and codeout = 20'hFFFFF.
